// File: rtl/core_arbiter_if.sv
// Bundle between two requesters, the arbiter, and the shared calculation core.
// req is a level held until the matching done/err pulse; core_start is a one-cycle pulse.
interface core_arbiter_if;
  logic [1:0]         req;
  logic signed [31:0] a0_0;
  logic signed [31:0] a1_0;
  logic signed [31:0] a0_1;
  logic signed [31:0] a1_1;
  logic [1:0]         done;
  logic [1:0]         err;
  logic signed [31:0] result;
  logic [7:0]         err_count;
  logic signed [31:0] core_a0;
  logic signed [31:0] core_a1;
  logic               core_start;
  logic               core_busy;
  logic signed [31:0] core_result;

  modport slave (
    input  req, a0_0, a1_0, a0_1, a1_1, core_busy, core_result,
    output done, err, result, err_count, core_a0, core_a1, core_start
  );

  modport master (
    output req, a0_0, a1_0, a0_1, a1_1, core_busy, core_result,
    input  done, err, result, err_count, core_a0, core_a1, core_start
  );
endinterface

// File: rtl/core_arbiter.sv
// Round-robin arbiter that shares one calculation core between two requesters,
// sequencing start/busy and aborting on start or run timeouts.
module core_arbiter #(
  parameter int START_WAIT     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  core_arbiter_if.slave        bus,
  output logic [2:0]           state_o
);

  localparam int CMAX = (TIMEOUT_CYCLES > START_WAIT) ? TIMEOUT_CYCLES : START_WAIT;
  localparam int CW   = $clog2(CMAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_FINISH    = 3'd4
  } state_e;

  state_e             state_q;
  logic               grant_q;
  logic               last_grant_q;
  logic [CW-1:0]      cnt_q;
  logic signed [31:0] a0_q;
  logic signed [31:0] a1_q;
  logic               start_q;
  logic [1:0]         done_q;
  logic [1:0]         err_q;
  logic signed [31:0] result_q;
  logic [7:0]         err_cnt_q;
  logic               win_c;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  always_comb begin
    win_c = 1'b0;
    if (bus.req == 2'b10)
      win_c = 1'b1;
    else if (bus.req == 2'b11)
      win_c = ~last_grant_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      a0_q         <= '0;
      a1_q         <= '0;
      start_q      <= 1'b0;
      done_q       <= 2'b00;
      err_q        <= 2'b00;
      result_q     <= '0;
      err_cnt_q    <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      case (state_q)
        S_IDLE: begin
          if (|bus.req) begin
            grant_q      <= win_c;
            last_grant_q <= win_c;
            a0_q         <= win_c ? bus.a0_1 : bus.a0_0;
            a1_q         <= win_c ? bus.a1_1 : bus.a1_0;
            start_q      <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (bus.core_busy) begin
            cnt_q   <= '0;
            state_q <= S_RUN;
          end else if (cnt_q == CW'(START_WAIT - 1)) begin
            err_q[grant_q] <= 1'b1;
            result_q       <= '0;
            err_cnt_q      <= (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            state_q        <= S_FINISH;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RUN: begin
          if (!bus.core_busy) begin
            done_q[grant_q] <= 1'b1;
            result_q        <= bus.core_result;
            state_q         <= S_FINISH;
          end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            err_q[grant_q] <= 1'b1;
            result_q       <= '0;
            err_cnt_q      <= (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            state_q        <= S_FINISH;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_FINISH: begin
          // done/err were registered on entry, so the pulse is visible this cycle.
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.result     = result_q;
  assign bus.err_count  = err_cnt_q;
  assign bus.core_a0    = a0_q;
  assign bus.core_a1    = a1_q;
  assign bus.core_start = start_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_core_arbiter.sv
// Bench for core_arbiter: acts as both requesters and the core, predicting winner,
// outcome cycle, result and error count from the arbitration and timeout rules.
module tb_core_arbiter;
  localparam int SW = 16;
  localparam int TO = 1024;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  core_arbiter_if bus ();
  logic [2:0] state_dbg;

  core_arbiter #(.START_WAIT(SW), .TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .state_o (state_dbg)
  );

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  int m_last = 1;
  int m_errs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, {31'd0, bus.core_start}, 32'd0);
    check({tag, "_done"}, {30'd0, bus.done}, 32'd0);
    check({tag, "_err"}, {30'd0, bus.err}, 32'd0);
    check({tag, "_result"}, bus.result, 32'd0);
    check({tag, "_err_count"}, {24'd0, bus.err_count}, 32'd0);
    check({tag, "_core_a0"}, bus.core_a0, 32'd0);
    check({tag, "_core_a1"}, bus.core_a1, 32'd0);
  endtask

  // driver: one full operation, entered and left at a negedge in an IDLE cycle
  task automatic do_op(input logic [1:0] rq, input int dly, input int len, input bit chg,
                       input bit use_f, input logic [31:0] f0, input logic [31:0] f1,
                       input logic [31:0] fres);
    logic [31:0] op [0:1][0:1];
    logic [31:0] res;
    int w, n, s, exp_e;
    bit to, extra;
    for (int r = 0; r < 2; r++) begin
      op[r][0] = $urandom;
      op[r][1] = $urandom;
    end
    res = $urandom | 32'd1;
    if (use_f) begin
      op[0][0] = f0;
      op[0][1] = f1;
      res = fres;
    end
    bus.a0_0 = op[0][0]; bus.a1_0 = op[0][1];
    bus.a0_1 = op[1][0]; bus.a1_1 = op[1][1];
    bus.req = rq;
    w = (rq == 2'b01) ? 0 : (rq == 2'b10) ? 1 : ((m_last == 0) ? 1 : 0);
    m_last = w;

    n = 0;
    while (n < 4) begin
      @(negedge clk);
      n++;
      if (bus.core_start) break;
    end
    check("start_latency", n, 1);
    if (!bus.core_start) return;
    s = cyc;
    check("core_a0_grant", bus.core_a0, op[w][0]);
    check("core_a1_grant", bus.core_a1, op[w][1]);

    to = 1'b0;
    if (dly >= SW) begin
      to = 1'b1;
      exp_e = s + SW + 1;
    end else if (len > TO) begin
      to = 1'b1;
      exp_e = s + 1 + dly + TO + 1;
    end else begin
      exp_e = s + 1 + dly + len + 1;
    end
    exp_q.push_back(to ? 32'd0 : res);

    extra = 1'b0;
    for (int k = 1; k <= SW + TO + dly + len + 8; k++) begin
      @(negedge clk);
      if ((bus.done | bus.err) != 2'b00) break;
      if (bus.core_start) extra = 1'b1;
      bus.core_busy = (k >= dly + 1) && (k < dly + 1 + len);
      bus.core_result = bus.core_busy ? $urandom : res;
      if (chg && k == dly + 3) begin
        bus.a0_0 = $urandom; bus.a1_0 = $urandom;
        bus.a0_1 = $urandom; bus.a1_1 = $urandom;
        bus.req = 2'b00;
      end
    end
    check("event_cycle", cyc - s, exp_e - s);
    check("done", {30'd0, bus.done}, to ? 32'd0 : (32'd1 << w));
    check("err", {30'd0, bus.err}, to ? (32'd1 << w) : 32'd0);
    check("result", bus.result, exp_q.pop_front());
    if (to && m_errs < 255) m_errs++;
    check("err_count", {24'd0, bus.err_count}, m_errs);
    check("core_a0_hold", bus.core_a0, op[w][0]);
    check("single_start", {31'd0, extra}, 32'd0);
    bus.core_busy = 1'b0;
    @(negedge clk);
    check("pulse_clear", {30'd0, bus.done | bus.err}, 32'd0);
  endtask

  initial begin
    int n;
    bus.req = 2'b00;
    bus.a0_0 = '0; bus.a1_0 = '0; bus.a0_1 = '0; bus.a1_1 = '0;
    bus.core_busy = 1'b0;
    bus.core_result = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // contention: 0,1,0,1
    for (int i = 0; i < 4; i++) do_op(2'b11, 1, 2, 1'b0, 1'b0, 0, 0, 0);

    // single request, directed values
    do_op(2'b01, 0, 3, 1'b0, 1'b1, 32'd5, -32'sd3, 32'd42);

    // boundaries: busy seen on last wait cycle, busy held exactly the run limit
    do_op(2'b10, SW - 1, 1, 1'b0, 1'b0, 0, 0, 0);
    do_op(2'b01, 0, TO, 1'b0, 1'b0, 0, 0, 0);

    // operand change and req drop while running
    do_op(2'b10, 0, 5, 1'b1, 1'b0, 0, 0, 0);
    do_op(2'b01, 2, 6, 1'b1, 1'b0, 0, 0, 0);

    // start timeout and run timeout
    do_op(2'b01, SW, 0, 1'b0, 1'b0, 0, 0, 0);
    do_op(2'b10, 2, TO + 5, 1'b0, 1'b0, 0, 0, 0);

    // randomized mix
    for (int i = 0; i < 40; i++)
      do_op(2'($urandom_range(1, 3)),
            ($urandom_range(0, 9) == 0) ? SW : $urandom_range(0, SW - 1),
            $urandom_range(1, 6), 1'b0, 1'b0, 0, 0, 0);

    // saturation of the error counter
    for (int i = 0; i < 300; i++)
      do_op(2'($urandom_range(1, 3)), SW, 0, 1'b0, 1'b0, 0, 0, 0);
    do_op(2'b01, 1, 2, 1'b0, 1'b0, 0, 0, 0);

    // reset while requester 0 is running; without reset a tie would go to requester 1
    bus.a0_0 = 32'h1234_5678; bus.a1_0 = 32'h0bad_cafe;
    bus.req = 2'b01;
    n = 0;
    while (n < 4) begin
      @(negedge clk);
      n++;
      if (bus.core_start) break;
    end
    check("rst_start_latency", n, 1);
    bus.core_busy = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    bus.core_busy = 1'b0;
    bus.req = 2'b00;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ((bus.done | bus.err) != 2'b00) n++;
    end
    check("reset_no_pulse", n, 0);
    rst_n = 1'b1;
    m_last = 1;
    m_errs = 0;
    exp_q.delete();
    @(negedge clk);
    do_op(2'b11, 1, 2, 1'b0, 1'b0, 0, 0, 0);
    do_op(2'b11, 0, 1, 1'b0, 1'b0, 0, 0, 0);

    bus.req = 2'b00;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
